// File: rtl/mux4_rr_sched_pkg.sv
// Shared definitions for the round-robin scheduler around the 4:1 single-bit mux.
// Holds the FSM encoding, requester geometry and the reset value of the rotation pointer.
package mux4_rr_sched_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    // Pointer starts at the top requester so requester 0 is searched first.
    localparam logic [SEL_W-1:0] LAST_RST = 2'd3;

    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [N_REQ-1:0] one;
        one = N_REQ'(1);
        return one << idx;
    endfunction

endpackage

// File: rtl/mux4_rr_sched_mux4.sv
// Team 4:1 single-bit multiplexer: f is the data line chosen by the 2-bit select.
module mux4 (
    input  logic [3:0] w,
    input  logic [1:0] s,
    output logic       f
);

    assign f = w[s];

endmodule

// File: rtl/mux4_rr_sched_rr_pick4.sv
// Combinational round-robin pick over four requests, searching last+1, last+2, last+3, last.
module rr_pick4
    import mux4_rr_sched_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] last,
    output logic [SEL_W-1:0] pick,
    output logic             any
);

    logic [SEL_W-1:0] idx;

    // Walk the search order backwards so the earliest set position is the one left standing.
    always_comb begin
        any  = |req;
        pick = last;
        idx  = last;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = last + SEL_W'(k);
            if (req[idx]) begin
                pick = idx;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_sched.sv
// Round-robin scheduler sharing one 4:1 mux between four serial requesters.
// Tenures are capped at MAX_HOLD cycles; f/valid trail gnt/s by one cycle.
module mux4_rr_sched
    import mux4_rr_sched_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] w,
    output logic [SEL_W-1:0] s,
    output logic [N_REQ-1:0] gnt,
    output logic             f,
    output logic             valid,
    output logic             busy
);

    logic [0:0]       state;
    logic [SEL_W-1:0] last;
    logic [HOLD_W-1:0] hold_cnt;

    logic [SEL_W-1:0] pick;
    logic             any;
    logic             mux_f;
    logic             in_grant;
    logic             cur_req;
    logic             hold_last;
    logic             release_now;
    logic             arbitrate;

    rr_pick4 u_pick (
        .req  (req),
        .last (last),
        .pick (pick),
        .any  (any)
    );

    mux4 u_mux (
        .w (w),
        .s (s),
        .f (mux_f)
    );

    assign in_grant    = (state == ST_GRANT);
    assign cur_req     = req[s];
    assign hold_last   = (hold_cnt == HOLD_W'(MAX_HOLD - 1));
    // Expiry and a dropped request in the same cycle collapse into one release.
    assign release_now = in_grant & (~cur_req | hold_last);
    assign arbitrate   = ~in_grant | release_now;

    // busy is the live view of the FSM state.
    assign busy = in_grant;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state    <= ST_IDLE;
            gnt      <= '0;
            s        <= '0;
            last     <= LAST_RST;
            hold_cnt <= '0;
            f        <= 1'b0;
            valid    <= 1'b0;
        end else begin
            f     <= mux_f & in_grant & cur_req;
            valid <= in_grant & cur_req;
            if (arbitrate) begin
                hold_cnt <= '0;
                if (any) begin
                    state <= ST_GRANT;
                    gnt   <= onehot(pick);
                    s     <= pick;
                    last  <= pick;
                end else begin
                    state <= ST_IDLE;
                    gnt   <= '0;
                end
            end else begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
            end
        end
    end

endmodule
